deck_dealer: RTL and testbench
==============================

Name: deck_dealer

Overview:
- Builds a shuffled 52-card deck and deals it into the initial game layout.
- 28 cards go to the seven tableau columns; the remaining 24 go to the talon, with an empty stock.
- Sits directly upstream of the talon/stock logic and drives its *_init buses and setup_ready.

Parameters:
- CARD_SIZE, 7, bits per card: [3:0] rank 1..13; [5:4] suit 0=clubs 1=diamonds 2=hearts 3=spades; [6] face-up. The value 0 means empty slot.
- DECK_SIZE, 52, cards in the deck.
- TALON_CARDS, 24, cards dealt to the talon.
- TABLEAU_CARDS, 28, cards dealt to the tableau (columns of 1..7).
- DEFAULT_SEED, 16'hACE1, LFSR seed used after reset and whenever a zero seed is loaded.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- seed_load  in  1  pulse: latch seed_in into the LFSR; accepted only when not busy
- seed_in  in  16  new LFSR seed
- start  in  1  pulse: begin shuffle and deal; ignored while busy
- busy  out  1  high from the cycle after start is accepted until DONE
- setup_ready  out  1  high while a valid dealt layout is held on the outputs
- tableau_cards  out  28*7  slot s holds one card; column c uses slots c(c+1)/2 .. c(c+1)/2+c, and the highest slot of each column is its top card
- talon_pile_init  out  24*7  slot k = talon card k
- stock_pile_init  out  24*7  always 0
- talon_size_init  out  5  24 once dealt
- stock_size_init  out  5  always 0

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; LFSR = DEFAULT_SEED.
  - busy=0, setup_ready=0.
  - All pile outputs and size outputs are 0.
  - Reset asserted mid-shuffle or mid-deal aborts immediately with no partial layout kept.
- States: IDLE -> INIT -> SHUFFLE -> DEAL -> DONE. DONE -> INIT on start.
- IDLE:
  - start=1 goes to INIT.
  - setup_ready=0.
- INIT (1 cycle):
  - Internal deck array (52 x 6-bit suit/rank) is loaded in parallel: deck[k] = {suit=k/13, rank=k%13+1}.
  - Index i = 51; setup_ready drops to 0; busy=1.
- SHUFFLE:
  - Fisher-Yates with rejection sampling. The LFSR advances every SHUFFLE cycle (16-bit Galois, mask 16'hB400, shift right).
  - j = lfsr[5:0] & m(i), where m(i) is the smallest 2^n-1 that is >= i.
  - If j <= i: swap deck[i] and deck[j], then decrement i.
  - Otherwise hold i and retry on the next cycle.
  - When a swap is done at i=1, go to DEAL.
  - j == i is a legal no-op swap.
  - Acceptance probability is >= 1/2 per cycle.
- DEAL (1 cycle):
  - tableau slot s gets deck[s], for s = 0..27.
  - Face-up bit is 1 only on slots 0, 2, 5, 9, 14, 20, 27; all other tableau cards have it 0.
  - talon slot k gets deck[28+k] with face-up bit 0.
  - talon_size_init=24, stock_size_init=0, stock_pile_init=0.
- DONE:
  - setup_ready=1, busy=0; outputs are held stable.
  - start=1 re-deals, continuing from the current LFSR state, so successive deals differ.
- Handshakes and conflicts:
  - start while busy is ignored; no restart and no queuing.
  - seed_load while busy is ignored.
  - seed_load and start in the same idle cycle: the seed is applied first, and the shuffle uses the new seed.
  - A seed_in of 0 loads DEFAULT_SEED, which avoids LFSR lockup.
- Latency and determinism:
  - start -> setup_ready is 3 + shuffle cycles; shuffle cycles are >= 51 and must be < 1000 for any nonzero seed.
  - Identical seed and start timing give a bit-identical layout.
- Arithmetic: i is a 6-bit down-counter; there is no wrap below 1.

Test Plan:
- Reset, then start with seed 16'hACE1 (no seed_load) -> setup_ready=1 within 1000 cycles. Required outputs: talon_size_init=24, stock_size_init=0, stock_pile_init=0. The 52 rank/suit codes across tableau and talon are all distinct, each rank is 1..13, and no slot is 0.
- Inspect the same deal -> face-up bit is 1 exactly at tableau slots 0, 2, 5, 9, 14, 20, 27 and 0 on all 24 talon cards.
- seed_load with 16'h1234, start; reset; seed_load with 16'h1234, start again -> both layouts are bit-identical. A second start without reload gives a different layout.
- seed_load with 16'h0000, start -> same layout as the DEFAULT_SEED run.
- Pulse start 10 cycles into SHUFFLE -> busy stays high and completion time matches the no-pulse run.
- Assert rst=0 mid-SHUFFLE -> busy=0, setup_ready=0 and all outputs 0 asynchronously. After release and start, the bench sees a valid deal identical to the fresh DEFAULT_SEED run.

Source files
------------

// File: rtl/deck_dealer.sv
// Shuffles a 52-card deck with an LFSR-driven Fisher-Yates pass and deals the
// opening layout: 28 cards to seven tableau columns and 24 to the talon.
module deck_dealer #(
  parameter int          CARD_SIZE     = 7,
  parameter int          DECK_SIZE     = 52,
  parameter int          TALON_CARDS   = 24,
  parameter int          TABLEAU_CARDS = 28,
  parameter logic [15:0] DEFAULT_SEED  = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               seed_load,
  input  logic [15:0]                        seed_in,
  input  logic                               start,
  output logic                               busy,
  output logic                               setup_ready,
  output logic [TABLEAU_CARDS*CARD_SIZE-1:0] tableau_cards,
  output logic [TALON_CARDS*CARD_SIZE-1:0]   talon_pile_init,
  output logic [TALON_CARDS*CARD_SIZE-1:0]   stock_pile_init,
  output logic [4:0]                         talon_size_init,
  output logic [4:0]                         stock_size_init,
  output logic [2:0]                         dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHUFFLE = 3'd2,
    DEAL    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                             state_q, state_d;
  logic [15:0]                        lfsr_q, lfsr_d, lfsr_step;
  logic [5:0]                         deck_q [DECK_SIZE];
  logic [5:0]                         deck_d [DECK_SIZE];
  logic [5:0]                         idx_q, idx_d, j_pick;
  logic [TABLEAU_CARDS*CARD_SIZE-1:0] tab_q, tab_d;
  logic [TALON_CARDS*CARD_SIZE-1:0]   tal_q, tal_d;
  logic [4:0]                         talon_size_q, talon_size_d;

  // Smallest all-ones mask covering i, so rejection keeps acceptance >= 1/2.
  function automatic logic [5:0] idx_mask(input logic [5:0] i);
    if (i <= 6'd1)       idx_mask = 6'd1;
    else if (i <= 6'd3)  idx_mask = 6'd3;
    else if (i <= 6'd7)  idx_mask = 6'd7;
    else if (i <= 6'd15) idx_mask = 6'd15;
    else if (i <= 6'd31) idx_mask = 6'd31;
    else                 idx_mask = 6'd63;
  endfunction

  function automatic logic is_column_top(input int s);
    case (s)
      0, 2, 5, 9, 14, 20, 27: is_column_top = 1'b1;
      default:                is_column_top = 1'b0;
    endcase
  endfunction

  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign j_pick    = lfsr_q[5:0] & idx_mask(idx_q);

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    deck_d       = deck_q;
    idx_d        = idx_q;
    tab_d        = tab_q;
    tal_d        = tal_q;
    talon_size_d = talon_size_q;
    case (state_q)
      IDLE, DONE: begin
        // Seed is applied in the same edge as start, so the shuffle sees it.
        if (seed_load) lfsr_d = (seed_in == 16'h0000) ? DEFAULT_SEED : seed_in;
        if (start) state_d = INIT;
      end
      INIT: begin
        for (int k = 0; k < DECK_SIZE; k++) begin
          deck_d[k] = {2'(k / 13), 4'(k % 13 + 1)};
        end
        idx_d   = 6'(DECK_SIZE - 1);
        state_d = SHUFFLE;
      end
      SHUFFLE: begin
        lfsr_d = lfsr_step;
        if (j_pick <= idx_q) begin
          deck_d[idx_q]  = deck_q[j_pick];
          deck_d[j_pick] = deck_q[idx_q];
          idx_d          = idx_q - 6'd1;
          if (idx_q == 6'd1) state_d = DEAL;
        end
      end
      DEAL: begin
        for (int s = 0; s < TABLEAU_CARDS; s++) begin
          tab_d[s*CARD_SIZE +: CARD_SIZE] = {is_column_top(s), deck_q[s]};
        end
        for (int k = 0; k < TALON_CARDS; k++) begin
          tal_d[k*CARD_SIZE +: CARD_SIZE] = {1'b0, deck_q[TABLEAU_CARDS + k]};
        end
        talon_size_d = 5'(TALON_CARDS);
        state_d      = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lfsr_q       <= DEFAULT_SEED;
      deck_q       <= '{default: '0};
      idx_q        <= '0;
      tab_q        <= '0;
      tal_q        <= '0;
      talon_size_q <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      deck_q       <= deck_d;
      idx_q        <= idx_d;
      tab_q        <= tab_d;
      tal_q        <= tal_d;
      talon_size_q <= talon_size_d;
    end
  end

  assign busy            = (state_q == INIT) || (state_q == SHUFFLE) || (state_q == DEAL);
  assign setup_ready     = (state_q == DONE);
  assign tableau_cards   = tab_q;
  assign talon_pile_init = tal_q;
  assign stock_pile_init = '0;
  assign talon_size_init = talon_size_q;
  assign stock_size_init = '0;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_deck_dealer.sv
// Directed bench for deck_dealer: deal validity, face-up pattern, seed
// reproducibility, ignored start/seed while busy, and async abort.
module tb_deck_dealer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         seed_load = 1'b0;
  logic [15:0]  seed_in = '0;
  logic         start = 1'b0;
  logic         busy, setup_ready;
  logic [195:0] tableau_cards;
  logic [167:0] talon_pile_init, stock_pile_init;
  logic [4:0]   talon_size_init, stock_size_init;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [195:0] tab_a, tab_b, tab_c, tab_d;
  logic [167:0] tal_a, tal_b, tal_c, tal_d;
  int           cyc_default, cyc, cyc_pre;

  deck_dealer dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in), .start(start),
    .busy(busy), .setup_ready(setup_ready), .tableau_cards(tableau_cards),
    .talon_pile_init(talon_pile_init), .stock_pile_init(stock_pile_init),
    .talon_size_init(talon_size_init), .stock_size_init(stock_size_init),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; seed_load = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_seed(input logic [15:0] s);
    @(negedge clk) begin seed_load = 1'b1; seed_in = s; end
    @(negedge clk) seed_load = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output int cnt);
    cnt = 0;
    while (!setup_ready && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_ready"}, setup_ready, 1'b1);
  endtask

  // Checks that the held layout is a full, duplicate-free deck with the right face-up pattern.
  task automatic validate(input string tag);
    logic [63:0] seen, exp_seen;
    logic [27:0] face_tab, exp_face;
    logic [23:0] face_tal;
    logic [6:0]  card;
    int          dups, zeros;
    seen = '0; exp_seen = '0; exp_face = '0; dups = 0; zeros = 0;
    for (int s = 0; s < 4; s++)
      for (int r = 1; r <= 13; r++) exp_seen[s*16 + r] = 1'b1;
    for (int c = 0; c < 7; c++) exp_face[c*(c+1)/2 + c] = 1'b1;
    for (int s = 0; s < 28; s++) begin
      card = tableau_cards[s*7 +: 7];
      face_tab[s] = card[6];
      if (card[5:0] == 6'd0) zeros++;
      if (seen[card[5:0]]) dups++;
      seen[card[5:0]] = 1'b1;
    end
    for (int k = 0; k < 24; k++) begin
      card = talon_pile_init[k*7 +: 7];
      face_tal[k] = card[6];
      if (card[5:0] == 6'd0) zeros++;
      if (seen[card[5:0]]) dups++;
      seen[card[5:0]] = 1'b1;
    end
    check({tag, "_codes"}, seen, exp_seen);
    check({tag, "_dups"}, dups, 0);
    check({tag, "_zeros"}, zeros, 0);
    check({tag, "_face_tab"}, face_tab, exp_face);
    check({tag, "_face_tal"}, face_tal, 24'h0);
    check({tag, "_talon_size"}, talon_size_init, 5'd24);
    check({tag, "_stock_size"}, stock_size_init, 5'd0);
    check({tag, "_stock_pile"}, stock_pile_init, 168'h0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", setup_ready, 1'b0);
    check("rst_tab", tableau_cards, 196'h0);
    check("rst_tal", talon_pile_init, 168'h0);
    check("rst_talon_size", talon_size_init, 5'd0);
    check("rst_state", dbg_state, 3'd0);
    do_reset();

    // Default-seed deal
    pulse_start();
    check("def_busy_after_start", busy, 1'b1);
    check("def_ready_low", setup_ready, 1'b0);
    wait_ready("def", cyc_default);
    check("def_min_latency", cyc_default >= 53, 1'b1);
    validate("def");
    tab_a = tableau_cards; tal_a = talon_pile_init;
    repeat (5) @(negedge clk);
    check("def_hold_tab", tableau_cards, tab_a);

    // Seed 1234 twice, identical timing
    do_reset();
    pulse_seed(16'h1234);
    pulse_start();
    wait_ready("s1", cyc);
    validate("s1");
    tab_b = tableau_cards; tal_b = talon_pile_init;
    do_reset();
    pulse_seed(16'h1234);
    pulse_start();
    wait_ready("s2", cyc);
    tab_c = tableau_cards; tal_c = talon_pile_init;
    check("s2_same_tab", tab_c, tab_b);
    check("s2_same_tal", tal_c, tal_b);
    check("s1_differs_default", {tab_b, tal_b} != {tab_a, tal_a}, 1'b1);
    // Re-deal continues from the current LFSR state
    pulse_start();
    check("redeal_ready_low", setup_ready, 1'b0);
    check("redeal_busy", busy, 1'b1);
    wait_ready("redeal", cyc);
    validate("redeal");
    tab_d = tableau_cards; tal_d = talon_pile_init;
    check("redeal_differs", {tab_d, tal_d} != {tab_c, tal_c}, 1'b1);

    // Zero seed loaded together with start maps to the default seed
    do_reset();
    @(negedge clk) begin seed_load = 1'b1; seed_in = 16'h0000; start = 1'b1; end
    @(negedge clk) begin seed_load = 1'b0; start = 1'b0; end
    wait_ready("zero", cyc);
    check("zero_cycles", cyc, cyc_default);
    check("zero_tab", tableau_cards, tab_a);
    check("zero_tal", talon_pile_init, tal_a);

    // start and seed_load while shuffling are ignored
    do_reset();
    pulse_start();
    cyc_pre = 0;
    repeat (11) begin
      @(negedge clk);
      cyc_pre++;
      check("ign_busy", busy, 1'b1);
    end
    start = 1'b1; seed_load = 1'b1; seed_in = 16'h5A5A;
    @(negedge clk) begin start = 1'b0; seed_load = 1'b0; end
    cyc_pre++;
    check("ign_busy_after", busy, 1'b1);
    wait_ready("ign", cyc);
    check("ign_cycles", cyc + cyc_pre, cyc_default);
    check("ign_tab", tableau_cards, tab_a);
    check("ign_tal", talon_pile_init, tal_a);

    // Asynchronous abort during a re-deal shuffle
    pulse_start();
    repeat (20) @(negedge clk);
    check("abort_pre_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_ready", setup_ready, 1'b0);
    check("abort_tab", tableau_cards, 196'h0);
    check("abort_tal", talon_pile_init, 168'h0);
    check("abort_talon_size", talon_size_init, 5'd0);
    check("abort_state", dbg_state, 3'd0);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    pulse_start();
    wait_ready("post", cyc);
    validate("post");
    check("post_cycles", cyc, cyc_default);
    check("post_tab", tableau_cards, tab_a);
    check("post_tal", talon_pile_init, tal_a);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
